// File: rtl/cipher_pkg.sv
// Shared types, constants and byte-wide combinational cores for the cipher transmit path.
// The encrypt, decrypt and hash cores are pure functions of a byte and an 8-bit key:
//   encrypt(d) = rotl8(d ^ key) + key
//   decrypt(e) = rotr8(e - key) ^ key      (exact inverse of encrypt)
//   hash(e)    = rotl8(e + key) ^ e
package cipher_pkg;

  typedef enum logic {ACCEPT, TAIL} tx_state_t;

  localparam logic [7:0] DIGEST_INIT_DEFAULT = 8'hA5;
  localparam logic [7:0] KEY_DEFAULT         = 8'h5A;

  function automatic logic [7:0] rotl8(input logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction

  function automatic logic [7:0] rotr8(input logic [7:0] x);
    return {x[0], x[7:1]};
  endfunction

  function automatic logic [7:0] encrypt8(input logic [7:0] d, input logic [7:0] key);
    return rotl8(d ^ key) + key;
  endfunction

  function automatic logic [7:0] decrypt8(input logic [7:0] e, input logic [7:0] key);
    return rotr8(e - key) ^ key;
  endfunction

  function automatic logic [7:0] hash8(input logic [7:0] e, input logic [7:0] key);
    logic [7:0] s;
    s = e + key;
    return rotl8(s) ^ e;
  endfunction

endpackage

// File: rtl/cipher_digest_acc.sv
// Rotate-XOR digest accumulator for one frame.
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset, loads DIGEST_INIT
//   clr     reload DIGEST_INIT (frame start); has priority over en
//   en      fold h into the accumulator: digest <= rotl8(digest) ^ h
//   h       per-byte hash value
//   digest  current accumulator value
module cipher_digest_acc
  import cipher_pkg::*;
#(
  parameter logic [7:0] DIGEST_INIT = DIGEST_INIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] h,
  output logic [7:0] digest
);

  logic [7:0] digest_q, digest_d;

  always_comb begin
    digest_d = digest_q;
    if (clr) begin
      digest_d = DIGEST_INIT;
    end else if (en) begin
      digest_d = rotl8(digest_q) ^ h;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digest_q <= DIGEST_INIT;
    end else begin
      digest_q <= digest_d;
    end
  end

  assign digest = digest_q;

endmodule

// File: rtl/cipher_frame_tx.sv
// Streaming frame transmitter: encrypts each accepted plaintext byte and, after the frame's
// final byte, appends one digest beat built from the hash of every ciphertext byte.
// Optional feature macro: ROUNDTRIP_CHECK_EN adds a decrypt self-check and the rt_err port.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   s_data/s_valid/s_last plaintext stream in, s_ready back-pressure out
//   m_data/m_valid/m_last ciphertext/digest stream out, m_ready in
//   m_is_digest           current beat is the digest (always also m_last)
//   frame_cnt             number of digest beats handed off, wraps
//   err_len               sticky, a frame was cut at MAX_LEN without s_last
//   rt_err                (ROUNDTRIP_CHECK_EN only) sticky decrypt(encrypt(x)) != x
module cipher_frame_tx
  import cipher_pkg::*;
#(
  parameter logic [7:0]  DIGEST_INIT = DIGEST_INIT_DEFAULT,
  parameter int unsigned MAX_LEN     = 256,
  parameter logic [7:0]  KEY         = KEY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  output logic        m_is_digest,
  input  logic        m_ready,
  output logic [15:0] frame_cnt,
  output logic        err_len
`ifdef ROUNDTRIP_CHECK_EN
  ,
  output logic        rt_err
`endif
);

  localparam logic [15:0] MaxLenM1 = 16'(MAX_LEN - 1);

  tx_state_t   state_q, state_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  m_data_q, m_data_d;
  logic        m_valid_q, m_valid_d;
  logic        m_last_q, m_last_d;
  logic        m_is_digest_q, m_is_digest_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        err_len_q, err_len_d;

  logic       slot_free;
  logic       accept;
  logic       max_hit;
  logic       tail_load;
  logic [7:0] enc;
  logic [7:0] hsh;
  logic [7:0] digest;

  // One output register and no skid buffer: a new beat may load only when the slot is
  // empty or is being drained this cycle.
  assign slot_free = !m_valid_q || m_ready;
  assign s_ready   = (state_q == ACCEPT) && slot_free;
  assign accept    = s_valid && s_ready;
  assign max_hit   = (byte_cnt_q == MaxLenM1);

  assign enc = encrypt8(s_data, KEY);
  assign hsh = hash8(enc, KEY);

  cipher_digest_acc #(
    .DIGEST_INIT(DIGEST_INIT)
  ) u_digest (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tail_load),
    .en    (accept),
    .h     (hsh),
    .digest(digest)
  );

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    m_data_d      = m_data_q;
    m_valid_d     = m_valid_q && !m_ready;
    m_last_d      = m_last_q;
    m_is_digest_d = m_is_digest_q;
    frame_cnt_d   = frame_cnt_q;
    err_len_d     = err_len_q;
    tail_load     = 1'b0;

    if (m_valid_q && m_ready && m_is_digest_q) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end

    unique case (state_q)
      ACCEPT: begin
        if (accept) begin
          m_data_d      = enc;
          m_valid_d     = 1'b1;
          m_last_d      = 1'b0;
          m_is_digest_d = 1'b0;
          byte_cnt_d    = byte_cnt_q + 16'd1;
          if (s_last || max_hit) begin
            state_d = TAIL;
          end
          if (max_hit && !s_last) begin
            err_len_d = 1'b1;
          end
        end
      end
      TAIL: begin
        // Accumulator already holds the final byte's hash (folded on the accept edge).
        if (slot_free) begin
          m_data_d      = digest;
          m_valid_d     = 1'b1;
          m_last_d      = 1'b1;
          m_is_digest_d = 1'b1;
          tail_load     = 1'b1;
          byte_cnt_d    = 16'd0;
          state_d       = ACCEPT;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ACCEPT;
      byte_cnt_q    <= 16'd0;
      m_data_q      <= 8'd0;
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
      m_is_digest_q <= 1'b0;
      frame_cnt_q   <= 16'd0;
      err_len_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      m_data_q      <= m_data_d;
      m_valid_q     <= m_valid_d;
      m_last_q      <= m_last_d;
      m_is_digest_q <= m_is_digest_d;
      frame_cnt_q   <= frame_cnt_d;
      err_len_q     <= err_len_d;
    end
  end

  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign m_last      = m_last_q;
  assign m_is_digest = m_is_digest_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_len     = err_len_q;

`ifdef ROUNDTRIP_CHECK_EN
  // Check runs one stage behind the datapath so it never lengthens the encrypt path.
  logic rt_mis_q, rt_mis_d;
  logic rt_err_q, rt_err_d;

  always_comb begin
    rt_mis_d = accept && (decrypt8(enc, KEY) != s_data);
    rt_err_d = rt_err_q || rt_mis_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rt_mis_q <= 1'b0;
      rt_err_q <= 1'b0;
    end else begin
      rt_mis_q <= rt_mis_d;
      rt_err_q <= rt_err_d;
    end
  end

  assign rt_err = rt_err_q;
`endif

endmodule

// File: tb/tb_cipher_frame_tx.sv
// Self-checking bench for cipher_frame_tx: table-driven directed frames, backpressure,
// MAX_LEN cut, mid-frame reset and randomized traffic checked against a frame-level model.
module tb_cipher_frame_tx;

  localparam logic [7:0] K    = 8'h5A;
  localparam int         INIT = 8'hA5;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic [7:0] exp_data;
    logic       exp_dig;
  } vec_t;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       dig;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] s_data;
  logic s_valid, s_last, m_ready;
  logic sel;

  logic s_ready_a, m_valid_a, m_last_a, m_dig_a, err_len_a;
  logic s_ready_b, m_valid_b, m_last_b, m_dig_b, err_len_b;
  logic [7:0] m_data_a, m_data_b;
  logic [15:0] frame_cnt_a, frame_cnt_b;
`ifdef ROUNDTRIP_CHECK_EN
  logic rt_err_a, rt_err_b;
`endif

  always #5 clk = ~clk;

  cipher_frame_tx #(.MAX_LEN(256)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready_a), .m_data(m_data_a), .m_valid(m_valid_a), .m_last(m_last_a),
    .m_is_digest(m_dig_a), .m_ready(m_ready), .frame_cnt(frame_cnt_a), .err_len(err_len_a)
`ifdef ROUNDTRIP_CHECK_EN
    , .rt_err(rt_err_a)
`endif
  );

  cipher_frame_tx #(.MAX_LEN(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready_b), .m_data(m_data_b), .m_valid(m_valid_b), .m_last(m_last_b),
    .m_is_digest(m_dig_b), .m_ready(m_ready), .frame_cnt(frame_cnt_b), .err_len(err_len_b)
`ifdef ROUNDTRIP_CHECK_EN
    , .rt_err(rt_err_b)
`endif
  );

  // Observed instance: sel=0 -> MAX_LEN 256, sel=1 -> MAX_LEN 4.
  logic s_ready_x, m_valid_x, m_last_x, m_dig_x, err_len_x;
  logic [7:0] m_data_x;
  logic [15:0] frame_cnt_x;
  assign s_ready_x   = sel ? s_ready_b : s_ready_a;
  assign m_valid_x   = sel ? m_valid_b : m_valid_a;
  assign m_last_x    = sel ? m_last_b : m_last_a;
  assign m_dig_x     = sel ? m_dig_b : m_dig_a;
  assign err_len_x   = sel ? err_len_b : err_len_a;
  assign m_data_x    = sel ? m_data_b : m_data_a;
  assign frame_cnt_x = sel ? frame_cnt_b : frame_cnt_a;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference cores in plain integer arithmetic.
  function automatic int rotl_i(input int x);
    return ((x * 2) % 256) + (x / 128);
  endfunction

  function automatic logic [7:0] ref_enc(input logic [7:0] d);
    return 8'((rotl_i(int'(d ^ K)) + int'(K)) % 256);
  endfunction

  function automatic logic [7:0] ref_hash(input logic [7:0] e);
    return 8'(rotl_i((int'(e) + int'(K)) % 256) ^ int'(e));
  endfunction

  // Model state, owned by the negedge monitor.
  beat_t      exp_q[$];
  logic [7:0] frame_q[$];
  int         exp_frames = 0;
  logic       exp_err = 1'b0;
  logic       acc_flag = 1'b0;
  int         acc_cyc = 0;
  int         cyc = 0;
  logic       post_rst = 1'b0;
  logic       hold = 1'b0;
  beat_t      held;
  logic [7:0] log_d[$];
  logic       log_g[$];
  int         log_c[$];

  initial begin : monitor
    int max_len;
    int acc;
    beat_t b;
    forever begin
      @(negedge clk);
      cyc++;
      max_len = sel ? 4 : 256;
      if (!rst_n) begin
        exp_q.delete();
        frame_q.delete();
        exp_frames = 0;
        exp_err    = 1'b0;
        hold       = 1'b0;
        acc_flag   = 1'b0;
        post_rst   = 1'b1;
      end else begin
        if (post_rst) begin
          chk("rst_m_valid", int'(m_valid_x), 0);
          chk("rst_m_data", int'(m_data_x), 0);
          chk("rst_m_last", int'(m_last_x), 0);
          chk("rst_m_is_digest", int'(m_dig_x), 0);
          chk("rst_frame_cnt", int'(frame_cnt_x), 0);
          chk("rst_err_len", int'(err_len_x), 0);
          post_rst = 1'b0;
        end
        chk("frame_cnt", int'(frame_cnt_x), exp_frames);
        chk("err_len", int'(err_len_x), int'(exp_err));
`ifdef ROUNDTRIP_CHECK_EN
        chk("rt_err", int'(sel ? rt_err_b : rt_err_a), 0);
`endif
        if (hold) begin
          chk("hold_valid", int'(m_valid_x), 1);
          chk("hold_data", int'(m_data_x), int'(held.d));
          chk("hold_last", int'(m_last_x), int'(held.last));
          chk("hold_dig", int'(m_dig_x), int'(held.dig));
        end
        if (m_valid_x && !m_ready) chk("s_ready_when_full", int'(s_ready_x), 0);
        if (m_valid_x && m_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", int'(m_data_x), -1);
          end else begin
            b = exp_q.pop_front();
            chk("beat_data", int'(m_data_x), int'(b.d));
            chk("beat_last", int'(m_last_x), int'(b.last));
            chk("beat_dig", int'(m_dig_x), int'(b.dig));
          end
          log_d.push_back(m_data_x);
          log_g.push_back(m_dig_x);
          log_c.push_back(cyc);
          if (m_dig_x) exp_frames++;
        end
        hold = m_valid_x && !m_ready;
        held = '{m_data_x, m_last_x, m_dig_x};
        if (s_valid && s_ready_x) begin
          frame_q.push_back(s_data);
          exp_q.push_back('{ref_enc(s_data), 1'b0, 1'b0});
          if (s_last || frame_q.size() == max_len) begin
            if (!s_last) exp_err = 1'b1;
            acc = INIT;
            foreach (frame_q[i]) acc = rotl_i(acc) ^ int'(ref_hash(ref_enc(frame_q[i])));
            exp_q.push_back('{8'(acc), 1'b1, 1'b1});
            frame_q.delete();
          end
          acc_flag = 1'b1;
          acc_cyc  = cyc;
        end
      end
    end
  end

  // m_ready driver: 0 always ready, 1 random, 2 pattern 1,0,0,1.
  int rdy_mode = 0;
  int pat_i = 0;
  logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  initial begin : ready_drv
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: m_ready = ($urandom_range(0, 3) != 0);
        2: begin m_ready = pat[pat_i % 4]; pat_i++; end
        default: m_ready = 1'b1;
      endcase
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    logic got;
    got = 1'b0;
    s_data = d; s_valid = 1'b1; s_last = l;
    for (int i = 0; i < 300 && !got; i++) begin
      @(posedge clk);
      #1;
      if (acc_flag) got = 1'b1;
    end
    if (!got) chk("send_timeout", 0, 1);
    acc_flag = 1'b0;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  vec_t t1[4];

  initial begin : main
    int t1_acc;
    int len;
    t1[0] = '{8'h00, 1'b0, 8'h0E, 1'b0};
    t1[1] = '{8'h5A, 1'b0, 8'h5A, 1'b0};
    t1[2] = '{8'hFF, 1'b1, 8'hA5, 1'b0};
    t1[3] = '{8'h00, 1'b0, 8'h6A, 1'b1};

    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; sel = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Test 1: 3-byte frame, always ready; expected bytes taken from the table.
    log_d.delete(); log_g.delete(); log_c.delete();
    send(t1[0].d, t1[0].last);
    t1_acc = acc_cyc;
    for (int i = 1; i < 3; i++) send(t1[i].d, t1[i].last);
    drain();
    chk("t1_beats", log_d.size(), 4);
    if (log_d.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t1_data", int'(log_d[i]), int'(t1[i].exp_data));
        chk("t1_dig", int'(log_g[i]), int'(t1[i].exp_dig));
      end
      chk("t1_latency", log_c[0], t1_acc + 1);
      chk("t1_no_gap", log_c[3] - log_c[0], 3);
    end
    chk("t1_frames", int'(frame_cnt_x), 1);

    // Test 2: 1-byte frame then 2-byte frame back to back.
    do_reset();
    log_d.delete(); log_g.delete(); log_c.delete();
    send(8'h3C, 1'b1);
    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    drain();
    chk("t2_beats", log_d.size(), 5);
    chk("t2_frames", int'(frame_cnt_x), 2);

    // Test 3: backpressure pattern over a 4-byte frame.
    rdy_mode = 2; pat_i = 0;
    for (int i = 0; i < 4; i++) send(8'(8'hC0 + i), (i == 3));
    drain();
    rdy_mode = 0;
    idle(2);
    chk("t3_frames", int'(frame_cnt_x), 3);

    // Test 4: MAX_LEN=4 instance, 6 bytes with only the 6th marked last.
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) send(8'(8'h10 * i + 3), (i == 5));
    drain();
    chk("t4_err_len", int'(err_len_x), 1);
    chk("t4_frames", int'(frame_cnt_x), 2);

    // Test 5: reset after the 2nd byte of a 5-byte frame, then a clean 2-byte frame.
    sel = 1'b0;
    do_reset();
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    do_reset();
    send(8'h77, 1'b0);
    send(8'h88, 1'b1);
    drain();
    chk("t5_frames", int'(frame_cnt_x), 1);

    // Test 6: full 256-byte frame, last coincides with MAX_LEN.
    for (int i = 0; i < 256; i++) send(8'(i), (i == 255));
    drain();
    chk("t6_err_len", int'(err_len_x), 0);
    chk("t6_frames", int'(frame_cnt_x), 2);

    // Randomized traffic on both instances with random backpressure and gaps.
    rdy_mode = 1;
    for (int f = 0; f < 20; f++) begin
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        send(8'($urandom_range(0, 255)), (i == len - 1));
        idle($urandom_range(0, 2));
      end
    end
    drain();
    sel = 1'b1;
    do_reset();
    for (int f = 0; f < 15; f++) begin
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) begin
        send(8'($urandom_range(0, 255)), (i == len - 1));
        idle($urandom_range(0, 2));
      end
    end
    drain();
    rdy_mode = 0;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
